// File: rtl/vga_fetch_ctrl_pkg.sv
// Shared definitions for the VGA frame fetch controller:
// register map, bit positions and FSM encoding.
package vga_fetch_ctrl_pkg;

  localparam logic [2:0] REG_CONTROL = 3'd0;
  localparam logic [2:0] REG_STATUS  = 3'd1;
  localparam logic [2:0] REG_S_ADDR  = 3'd2;
  localparam logic [2:0] REG_LONGTH  = 3'd3;
  localparam logic [2:0] REG_START   = 3'd4;

  localparam int CTRL_CONT   = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_OVERRUN = 2;

  localparam int START_GO = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_PUSH  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/vga_fetch_ctrl.sv
// Frame fetch controller: reads LONGTH words from S_ADDR
// over an Avalon master and pushes them into a pixel FIFO.
module vga_fetch_ctrl
  import vga_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              avs_s1_chipselect,
  input  logic [2:0]        avs_s1_address,
  input  logic              avs_s1_read,
  input  logic              avs_s1_write,
  input  logic [31:0]       avs_s1_writedata,
  output logic [31:0]       avs_s1_readdata,
  output logic              avs_s1_irq,
  output logic [ADDR_W-1:0] avm_read_address,
  output logic              avm_read_read,
  input  logic [31:0]       avm_read_readdata,
  input  logic              avm_read_waitrequest,
  output logic              fifo_write_write,
  output logic [31:0]       fifo_write_writedata,
  input  logic              fifo_write_waitrequest,
  input  logic              frame_start
);

  state_e state_q, state_d;

  logic [1:0]        ctrl_q, ctrl_d;
  logic              done_q, done_d;
  logic              ovr_q, ovr_d;
  logic              irq_q;
  logic              fs_q;
  logic [ADDR_W-1:0] s_addr_q;
  logic [LEN_W-1:0]  longth_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [LEN_W-1:0]  remaining_q;
  logic [31:0]       word_q;

  logic              wr_en;
  logic              wr_ctrl;
  logic              wr_status;
  logic              wr_s_addr;
  logic              wr_longth;
  logic              start_wr;
  logic              fs_rise;
  logic              trigger;
  logic              busy;
  logic              go;
  logic              rd_ok;
  logic              push_ok;
  logic              last;
  logic [ADDR_W-1:0] wd_addr;
  logic [31:0]       status_w;
  logic              unused_wdata;

  assign wr_en     = avs_s1_chipselect & avs_s1_write;
  assign wr_ctrl   = wr_en & (avs_s1_address == REG_CONTROL);
  assign wr_status = wr_en & (avs_s1_address == REG_STATUS);
  assign wr_s_addr = wr_en & (avs_s1_address == REG_S_ADDR);
  assign wr_longth = wr_en & (avs_s1_address == REG_LONGTH);
  assign start_wr  = wr_en & (avs_s1_address == REG_START)
                   & avs_s1_writedata[START_GO];

  assign wd_addr      = ADDR_W'(avs_s1_writedata);
  assign unused_wdata = ^avs_s1_writedata;

  // A START write and a frame_start edge together are one trigger.
  assign fs_rise = frame_start & ~fs_q;
  assign trigger = start_wr | (fs_rise & ctrl_q[CTRL_CONT]);
  assign busy    = (state_q != S_IDLE);
  assign go      = trigger & ~busy;

  assign rd_ok   = (state_q == S_FETCH) & ~avm_read_waitrequest;
  assign push_ok = (state_q == S_PUSH) & ~fifo_write_waitrequest;
  assign last    = (remaining_q == LEN_W'(1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (trigger) begin
          if (longth_q == '0) state_d = S_DONE;
          else                state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (!avm_read_waitrequest) state_d = S_PUSH;
      end
      S_PUSH: begin
        if (!fifo_write_waitrequest) begin
          if (last) state_d = S_DONE;
          else      state_d = S_FETCH;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Setting done in DONE wins over a same-cycle W1C.
  always_comb begin
    ctrl_d = wr_ctrl ? avs_s1_writedata[1:0] : ctrl_q;
    done_d = (done_q & ~(wr_status & avs_s1_writedata[ST_DONE]))
           | (state_q == S_DONE);
    ovr_d  = (ovr_q & ~(wr_status & avs_s1_writedata[ST_OVERRUN]))
           | (trigger & busy);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q   <= '0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      irq_q    <= 1'b0;
      fs_q     <= 1'b0;
      s_addr_q <= '0;
      longth_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      done_q <= done_d;
      ovr_q  <= ovr_d;
      irq_q  <= done_d & ctrl_d[CTRL_IRQ_EN];
      fs_q   <= frame_start;
      if (wr_s_addr) s_addr_q <= {wd_addr[ADDR_W-1:2], 2'b00};
      if (wr_longth) longth_q <= LEN_W'(avs_s1_writedata);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_addr_q  <= '0;
      remaining_q <= '0;
      word_q      <= '0;
    end else if (go) begin
      cur_addr_q  <= s_addr_q;
      remaining_q <= longth_q;
    end else if (rd_ok) begin
      word_q <= avm_read_readdata;
    end else if (push_ok) begin
      remaining_q <= remaining_q - LEN_W'(1);
      cur_addr_q  <= cur_addr_q + ADDR_W'(4);
    end
  end

  assign avm_read_read    = (state_q == S_FETCH);
  assign fifo_write_write = (state_q == S_PUSH);
  assign avm_read_address = avm_read_read ? cur_addr_q : '0;
  assign fifo_write_writedata = fifo_write_write ? word_q : '0;
  assign avs_s1_irq = irq_q;

  always_comb begin
    status_w = '0;
    status_w[ST_BUSY]    = busy;
    status_w[ST_DONE]    = done_q;
    status_w[ST_OVERRUN] = ovr_q;
  end

  always_comb begin
    avs_s1_readdata = '0;
    if (avs_s1_chipselect && avs_s1_read) begin
      case (avs_s1_address)
        REG_CONTROL: avs_s1_readdata = {30'd0, ctrl_q};
        REG_STATUS:  avs_s1_readdata = status_w;
        REG_S_ADDR:  avs_s1_readdata = 32'(s_addr_q);
        REG_LONGTH:  avs_s1_readdata = 32'(longth_q);
        default:     avs_s1_readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fetch_ctrl.sv
// Self-checking bench for vga_fetch_ctrl: directed steps with
// randomized stalls against a simple address/data memory model.
module tb_vga_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        avs_s1_chipselect = 1'b0;
  logic [2:0]  avs_s1_address = '0;
  logic        avs_s1_read = 1'b0;
  logic        avs_s1_write = 1'b0;
  logic [31:0] avs_s1_writedata = '0;
  logic [31:0] avs_s1_readdata;
  logic        avs_s1_irq;
  logic [31:0] avm_read_address;
  logic        avm_read_read;
  logic [31:0] avm_read_readdata = '0;
  logic        avm_read_waitrequest = 1'b0;
  logic        fifo_write_write;
  logic [31:0] fifo_write_writedata;
  logic        fifo_write_waitrequest = 1'b0;
  logic        frame_start = 1'b0;

  int tests = 0;
  int fails = 0;

  vga_fetch_ctrl #(.ADDR_W(32), .LEN_W(24)) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .avs_s1_chipselect      (avs_s1_chipselect),
    .avs_s1_address         (avs_s1_address),
    .avs_s1_read            (avs_s1_read),
    .avs_s1_write           (avs_s1_write),
    .avs_s1_writedata       (avs_s1_writedata),
    .avs_s1_readdata        (avs_s1_readdata),
    .avs_s1_irq             (avs_s1_irq),
    .avm_read_address       (avm_read_address),
    .avm_read_read          (avm_read_read),
    .avm_read_readdata      (avm_read_readdata),
    .avm_read_waitrequest   (avm_read_waitrequest),
    .fifo_write_write       (fifo_write_write),
    .fifo_write_writedata   (fifo_write_writedata),
    .fifo_write_waitrequest (fifo_write_waitrequest),
    .frame_start            (frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5BD1E995;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
    avs_s1_chipselect = 1'b1;
    avs_s1_write = 1'b1;
    avs_s1_read = 1'b0;
    avs_s1_address = a;
    avs_s1_writedata = d;
    @(negedge clk);
    avs_s1_chipselect = 1'b0;
    avs_s1_write = 1'b0;
    avs_s1_writedata = '0;
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
    avs_s1_chipselect = 1'b1;
    avs_s1_read = 1'b1;
    avs_s1_write = 1'b0;
    avs_s1_address = a;
    #1;
    d = avs_s1_readdata;
    avs_s1_read = 1'b0;
    avs_s1_chipselect = 1'b0;
  endtask

  task automatic idle_check(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      check(tag, {31'd0, avm_read_read}, 32'd0);
      @(negedge clk);
    end
  endtask

  // mode: 0 no stalls, 1 random stalls, 2 first read 5 / first push 3.
  // kick: 0 START write, 1 frame_start pulse.
  // mid_kind: 0 none, 1 frame_start pulse, 2 S_ADDR/LONGTH rewrite.
  task automatic run_frame(input int n, input logic [31:0] base,
                           input int mode, input int kick,
                           input int mid_at, input int mid_kind,
                           input bit exp_irq, input string tag);
    int reads = 0;
    int pushes = 0;
    int cyc = 0;
    int rst_cnt = 0;
    int fst_cnt = 0;
    bit seen = 1'b0;
    bit prev_rs = 1'b0;
    bit prev_fs = 1'b0;
    logic [31:0] prev_a = '0;
    logic [31:0] prev_d = '0;
    reg_write(3'd1, 32'h6);
    reg_write(3'd2, base);
    reg_write(3'd3, n);
    if (kick == 0) begin
      reg_write(3'd4, 32'h1);
    end else begin
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
    end
    while (!seen && cyc < 20 * n + 50) begin
      if (prev_rs) begin
        check({tag, " rd hold"}, {31'd0, avm_read_read}, 32'd1);
        check({tag, " addr hold"}, avm_read_address, prev_a);
      end
      if (prev_fs) begin
        check({tag, " wr hold"}, {31'd0, fifo_write_write}, 32'd1);
        check({tag, " data hold"}, fifo_write_writedata, prev_d);
      end
      case (mode)
        1: begin
          avm_read_waitrequest = ($urandom_range(0, 2) == 0);
          fifo_write_waitrequest = ($urandom_range(0, 2) == 0);
        end
        2: begin
          avm_read_waitrequest = (reads == 0) && (rst_cnt < 5);
          fifo_write_waitrequest = (pushes == 0) && (fst_cnt < 3);
        end
        default: begin
          avm_read_waitrequest = 1'b0;
          fifo_write_waitrequest = 1'b0;
        end
      endcase
      avm_read_readdata = mem(avm_read_address);
      prev_rs = avm_read_read && avm_read_waitrequest;
      prev_fs = fifo_write_write && fifo_write_waitrequest;
      prev_a = avm_read_address;
      prev_d = fifo_write_writedata;
      if (prev_rs) rst_cnt++;
      if (prev_fs) fst_cnt++;
      if (avm_read_read && !avm_read_waitrequest) begin
        check({tag, " rd addr"}, avm_read_address,
              base + 32'(4 * reads));
        reads++;
      end
      if (fifo_write_write && !fifo_write_waitrequest) begin
        check({tag, " push data"}, fifo_write_writedata,
              mem(base + 32'(4 * pushes)));
        pushes++;
      end
      frame_start = (mid_kind == 1) && (cyc == mid_at);
      avs_s1_chipselect = 1'b1;
      if (mid_kind == 2 && (cyc == mid_at || cyc == mid_at + 1)) begin
        avs_s1_read = 1'b0;
        avs_s1_write = 1'b1;
        avs_s1_address = (cyc == mid_at) ? 3'd3 : 3'd2;
        avs_s1_writedata = (cyc == mid_at) ? 32'd5 : 32'h0000_7000;
        #1;
      end else begin
        avs_s1_write = 1'b0;
        avs_s1_read = 1'b1;
        avs_s1_address = 3'd1;
        #1;
        seen = avs_s1_readdata[1];
      end
      @(negedge clk);
      cyc++;
    end
    avs_s1_chipselect = 1'b0;
    avs_s1_read = 1'b0;
    avs_s1_write = 1'b0;
    avs_s1_writedata = '0;
    frame_start = 1'b0;
    avm_read_waitrequest = 1'b0;
    fifo_write_waitrequest = 1'b0;
    check({tag, " done seen"}, {31'd0, seen}, 32'd1);
    check({tag, " read count"}, reads, n);
    check({tag, " push count"}, pushes, n);
    check({tag, " irq"}, {31'd0, avs_s1_irq}, {31'd0, exp_irq});
    if (mode == 0)
      check({tag, " throughput"}, {31'd0, cyc <= 2 * n + 2}, 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    repeat (3) @(negedge clk);
    check("rst read", {31'd0, avm_read_read}, 32'd0);
    check("rst push", {31'd0, fifo_write_write}, 32'd0);
    check("rst irq", {31'd0, avs_s1_irq}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    reg_read(3'd0, rd); check("rst control", rd, 32'd0);
    reg_read(3'd1, rd); check("rst status", rd, 32'd0);
    reg_read(3'd2, rd); check("rst s_addr", rd, 32'd0);
    reg_read(3'd3, rd); check("rst longth", rd, 32'd0);
    @(negedge clk);
    idle_check(4, "idle after rst");

    reg_write(3'd2, 32'h1234_5677);
    reg_read(3'd2, rd); check("s_addr align", rd, 32'h1234_5674);
    @(negedge clk);
    reg_write(3'd5, 32'hFFFF_FFFF);
    reg_read(3'd5, rd); check("offset 5", rd, 32'd0);
    @(negedge clk);
    reg_write(3'd3, 32'hFF12_3456);
    reg_read(3'd3, rd); check("longth width", rd, 32'h0012_3456);
    @(negedge clk);

    // Zero-length frame and set-wins-over-W1C in DONE.
    reg_write(3'd3, 32'd0);
    reg_write(3'd4, 32'h1);
    check("len0 no read", {31'd0, avm_read_read}, 32'd0);
    reg_read(3'd1, rd); check("len0 busy", rd, 32'h1);
    reg_write(3'd1, 32'h2);
    check("len0 no read2", {31'd0, avm_read_read}, 32'd0);
    reg_read(3'd1, rd); check("len0 done", rd, 32'h2);
    reg_write(3'd1, 32'h2);
    reg_read(3'd1, rd); check("done w1c", rd, 32'h0);
    @(negedge clk);

    reg_write(3'd0, 32'h2);
    run_frame(200, 32'h0090_0000, 0, 0, -1, 0, 1'b1, "long");
    reg_write(3'd1, 32'h2);
    check("irq clear", {31'd0, avs_s1_irq}, 32'd0);

    reg_write(3'd0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      run_frame($urandom_range(1, 20), $urandom & 32'hFFFF_FFFC,
                1, 0, -1, 0, 1'b0, "rand");
    end
    run_frame(6, 32'h0000_1000, 2, 0, -1, 0, 1'b0, "stall");

    reg_write(3'd0, 32'h2);
    run_frame(10, 32'h0000_2000, 1, 0, 3, 2, 1'b1, "rewrite");

    reg_write(3'd0, 32'h1);
    run_frame(8, 32'h0000_3000, 0, 1, 4, 1, 1'b0, "overrun");
    reg_read(3'd1, rd); check("overrun set", rd, 32'h6);
    @(negedge clk);
    idle_check(5, "single frame");
    run_frame(4, 32'h0000_4000, 0, 1, -1, 0, 1'b0, "next pulse");

    reg_write(3'd0, 32'h2);
    run_frame(2, 32'hFFFF_FFFC, 1, 0, -1, 0, 1'b1, "wrap");

    // Reset in the middle of a stalled fetch.
    avm_read_waitrequest = 1'b1;
    reg_write(3'd2, 32'h0000_5000);
    reg_write(3'd3, 32'd8);
    reg_write(3'd4, 32'h1);
    check("pre rst read", {31'd0, avm_read_read}, 32'd1);
    check("pre rst irq", {31'd0, avs_s1_irq}, 32'd1);
    avs_s1_chipselect = 1'b1;
    avs_s1_read = 1'b1;
    avs_s1_address = 3'd2;
    #2;
    reset_n = 1'b0;
    #1;
    check("mid rst read", {31'd0, avm_read_read}, 32'd0);
    check("mid rst addr", avm_read_address, 32'd0);
    check("mid rst push", {31'd0, fifo_write_write}, 32'd0);
    check("mid rst wdata", fifo_write_writedata, 32'd0);
    check("mid rst irq", {31'd0, avs_s1_irq}, 32'd0);
    check("mid rst rdata", avs_s1_readdata, 32'd0);
    avs_s1_chipselect = 1'b0;
    avs_s1_read = 1'b0;
    @(negedge clk);
    avm_read_waitrequest = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    reg_read(3'd0, rd); check("post rst control", rd, 32'd0);
    reg_read(3'd1, rd); check("post rst status", rd, 32'd0);
    reg_read(3'd2, rd); check("post rst s_addr", rd, 32'd0);
    reg_read(3'd3, rd); check("post rst longth", rd, 32'd0);
    @(negedge clk);
    idle_check(5, "post rst idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_fetch_ctrl.md
VGA_FETCH_CTRL -- requirements
Module: vga_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the master address and register width.
REQ-002 The block SHALL have parameter LEN_W, default 24, meaning the LONGTH word-count width.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 avs_s1_chipselect  in  1  slave select.
REQ-006 avs_s1_address  in  3  register word offset.
REQ-007 avs_s1_read  in  1  register read strobe.
REQ-008 avs_s1_write  in  1  register write strobe.
REQ-009 avs_s1_writedata  in  32  register write data.
REQ-010 avs_s1_readdata  out  32  register read data.
REQ-011 avs_s1_irq  out  1  frame-done interrupt.
REQ-012 avm_read_address  out  ADDR_W  master byte address.
REQ-013 avm_read_read  out  1  master read request.
REQ-014 avm_read_readdata  in  32  master read data.
REQ-015 avm_read_waitrequest  in  1  master stall.
REQ-016 fifo_write_write  out  1  pixel FIFO push.
REQ-017 fifo_write_writedata  out  32  pixel word.
REQ-018 fifo_write_waitrequest  in  1  FIFO full/stall.
REQ-019 frame_start  in  1  vertical-sync frame trigger, synchronous to clk.

Function
REQ-020 The block SHALL provide these registers:
- 0 CONTROL: b0 continuous, b1 irq_en.
- 1 STATUS: b0 busy (RO), b1 done (W1C), b2 overrun (W1C).
- 2 S_ADDR: bits[1:0] forced 0.
- 3 LONGTH: LEN_W words.
- 4 START: writing b0=1 triggers a frame.
- Offsets 5-7: read 0, writes ignored.
REQ-021 avs_s1_readdata SHALL be combinational from the addressed register, with zero wait states.
REQ-022 A trigger SHALL be either a START write or a rising edge of frame_start while CONTROL.b0=1.
REQ-023 A START write and a frame_start edge in the same cycle SHALL produce exactly one frame.
REQ-024 FSM states SHALL be IDLE, FETCH, PUSH and DONE.
REQ-025 IDLE SHALL do the following on a trigger:
- Latch S_ADDR into cur_addr and LONGTH into remaining.
- Go to DONE if LONGTH=0; otherwise go to FETCH.
REQ-026 FETCH SHALL do the following:
- Drive avm_read_read=1 and avm_read_address=cur_addr.
- Hold both stable while avm_read_waitrequest=1.
- On waitrequest=0, capture readdata and go to PUSH.
REQ-027 PUSH SHALL do the following:
- Drive fifo_write_write=1 with the captured word, held while fifo_write_waitrequest=1.
- On acceptance, decrement remaining and add 4 to cur_addr, modulo 2^ADDR_W.
- Go to DONE if remaining reaches 0; otherwise go to FETCH.
REQ-028 DONE SHALL last 1 cycle, set STATUS.done=1 and return to IDLE.
REQ-029 Minimum throughput SHALL be 1 word per 2 cycles, and no word SHALL be duplicated or dropped under any stall pattern.
REQ-030 STATUS.busy SHALL be 1 in FETCH, PUSH and DONE.
REQ-031 A trigger while busy SHALL be ignored and SHALL set STATUS.overrun=1.
REQ-032 Writes to S_ADDR, LONGTH or CONTROL during a frame SHALL NOT affect that frame.
REQ-033 Clearing CONTROL.b0 mid-frame SHALL let the current frame complete.
REQ-034 avs_s1_irq SHALL equal STATUS.done AND CONTROL.b1, as a registered level.
REQ-035 A W1C write to done in the same cycle as DONE SHALL leave done=1, because set wins.

Reset
REQ-036 While reset_n=0, the block SHALL do the following:
- Enter IDLE.
- Force all registers, cur_addr and remaining to 0.
- Force all outputs to 0 immediately, including mid-transaction.
REQ-037 After reset_n deasserts, no transfer SHALL start until a new trigger.

Structure
REQ-038 Register offsets, bit positions and the FSM state encoding SHALL live in a shared package, vga_fetch_ctrl_pkg.
REQ-039 The block SHALL be one flat module with no sub-modules, because the register file and FSM are small.

Verification
REQ-040 S_ADDR=0x900000, LONGTH=200, CONTROL=2, START -> 200 reads at 0x900000..0x90031C, 200 in-order pushes, done=1, irq=1.
REQ-041 LONGTH=0, START -> no avm_read_read, done=1 two cycles after the write.
REQ-042 waitrequest held for 5 cycles on one read, and FIFO waitrequest held for 3 cycles -> address, data and strobes stable, word count exact.
REQ-043 CONTROL=1, frame_start pulses mid-frame -> overrun=1, a single frame, a new frame on the next idle pulse.
REQ-044 reset_n low mid-FETCH -> all outputs 0 in the same cycle, registers 0, idle after release.
REQ-045 S_ADDR=0xFFFFFFFC, LONGTH=2 -> addresses 0xFFFFFFFC then 0x00000000.
